// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types and elaboration helpers for the stochastic rank filter
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } sc_state_e;

  function automatic int rank_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int len);
    return $clog2(len + 1);
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // The final CAS stage is never registered here: the top registers it together with the rank mux
  function automatic bit reg_after(input int stage, input int n, input int rs);
    return ((stage % rs) == 0) && (stage < n);
  endfunction

endpackage

// File: rtl/sc_cas_net.sv
// rtl/sc_cas_net.sv - pipelined odd-even transposition AND/OR sorting network
module sc_cas_net
  import sc_pkg::*;
#(
  parameter int N          = 9,
  parameter int REG_STAGES = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  input  logic [N-1:0] i_lanes,
  output logic [N-1:0] o_lanes,
  output logic         o_out_valid
);

  // Lane 0 ends up holding the minimum and lane N-1 the maximum
  for (genvar s = 0; s < N; s++) begin : g_stage
    logic [N-1:0] w_in;
    logic         w_vin;
    logic [N-1:0] w_cas;
    logic [N-1:0] w_out;
    logic         w_vout;

    if (s == 0) begin : g_first
      assign w_in  = i_lanes;
      assign w_vin = i_in_valid;
    end else begin : g_next
      assign w_in  = g_stage[s-1].w_out;
      assign w_vin = g_stage[s-1].w_vout;
    end

    // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
    for (genvar l = 0; l < N; l++) begin : g_lane
      if (((l % 2) == (s % 2)) && (l + 1 < N)) begin : g_lo
        assign w_cas[l] = w_in[l] & w_in[l+1];
      end else if (((l % 2) != (s % 2)) && (l >= 1)) begin : g_hi
        assign w_cas[l] = w_in[l-1] | w_in[l];
      end else begin : g_pass
        assign w_cas[l] = w_in[l];
      end
    end

    if (reg_after(s + 1, N, REG_STAGES)) begin : g_reg
      logic [N-1:0] r_lane;
      logic         r_vld;

      // Pipeline register: lanes and their valid bit advance together
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_lane <= '0;
          r_vld  <= 1'b0;
        end else begin
          r_lane <= w_cas;
          r_vld  <= w_vin;
        end
      end

      assign w_out  = r_lane;
      assign w_vout = r_vld;
    end else begin : g_comb
      assign w_out  = w_cas;
      assign w_vout = w_vin;
    end
  end

  assign o_lanes     = g_stage[N-1].w_out;
  assign o_out_valid = g_stage[N-1].w_vout;

endmodule

// File: rtl/sc_rank_filter_acc.sv
// rtl/sc_rank_filter_acc.sv - stochastic rank-order filter with framed ones accumulator
module sc_rank_filter_acc
  import sc_pkg::*;
#(
  parameter  int N          = 9,
  parameter  int REG_STAGES = 3,
  parameter  int STREAM_LEN = 256,
  localparam int RW         = rank_width(N),
  localparam int CW         = count_width(STREAM_LEN)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [RW-1:0] i_rank_sel,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [N-1:0]  i_window,
  output logic          o_bit_valid,
  output logic          o_bit_out,
  output logic          o_busy,
  output logic          o_done,
  output logic [CW-1:0] o_count
);

  localparam int            LAT      = ceil_div(N, REG_STAGES);
  localparam int            IW       = $clog2(LAT + 1);
  localparam logic [RW-1:0] RANK_MAX = RW'(N - 1);
  localparam logic [RW-1:0] RANK_MED = RW'((N - 1) / 2);
  localparam logic [CW-1:0] LEN_LAST = CW'(STREAM_LEN - 1);
  localparam logic [CW-1:0] LEN_FULL = CW'(STREAM_LEN);

  sc_state_e     r_state;
  sc_state_e     w_next;
  logic [RW-1:0] r_rank;
  logic [CW-1:0] r_acc;
  logic [CW-1:0] r_ones;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_infl;
  logic          r_bit_valid;
  logic          r_bit_out;
  logic [N-1:0]  w_net_lanes;
  logic          w_net_valid;
  logic          w_sel;
  logic          w_accept;
  logic          w_start_ok;
  logic          w_in_ready;
  logic          w_busy;
  logic          w_done;

  assign w_accept   = i_in_valid && w_in_ready;
  assign w_start_ok = i_start && (r_state == IDLE);

  sc_cas_net #(
    .N          (N),
    .REG_STAGES (REG_STAGES)
  ) u_net (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (w_accept),
    .i_lanes     (i_window),
    .o_lanes     (w_net_lanes),
    .o_out_valid (w_net_valid)
  );

  assign w_sel = w_net_lanes[r_rank];

  // Rank tap register: last CAS stage plus mux, bit forced low when not valid
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_valid <= 1'b0;
      r_bit_out   <= 1'b0;
    end else begin
      r_bit_valid <= w_net_valid;
      r_bit_out   <= w_net_valid & w_sel;
    end
  end

  // Windows in flight between acceptance and the rank tap output
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_infl <= '0;
    end else begin
      case ({w_accept, r_bit_valid})
        2'b10:   r_infl <= r_infl + IW'(1);
        2'b01:   r_infl <= r_infl - IW'(1);
        default: r_infl <= r_infl;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (w_accept && (r_acc == LEN_LAST)) w_next = FLUSH;
      FLUSH:   if (r_infl == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_in_ready = (r_state == RUN) && (r_acc < LEN_FULL);
    w_busy     = (r_state == RUN) || (r_state == FLUSH);
    w_done     = (r_state == DONE);
  end

  // Frame counters, rank latch and the result captured as the frame closes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rank  <= RANK_MED;
      r_acc   <= '0;
      r_ones  <= '0;
      r_count <= '0;
    end else begin
      if (w_start_ok) begin
        r_acc  <= '0;
        r_ones <= '0;
        r_rank <= (i_rank_sel > RANK_MAX) ? RANK_MAX : i_rank_sel;
      end else begin
        if (w_accept) r_acc <= r_acc + CW'(1);
        if (r_bit_valid && r_bit_out) r_ones <= r_ones + CW'(1);
      end
      if ((r_state == FLUSH) && (w_next == DONE)) r_count <= r_ones;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_bit_valid = r_bit_valid;
  assign o_bit_out   = r_bit_out;
  assign o_busy      = w_busy;
  assign o_done      = w_done;
  assign o_count     = r_count;

endmodule

// File: tb/tb_sc_rank_filter_acc.sv
// tb/tb_sc_rank_filter_acc.sv - randomized model-checked bench for sc_rank_filter_acc
module tb_sc_rank_filter_acc;

  localparam int LEN   = 256;
  localparam int CWT   = $clog2(LEN + 1);
  localparam int LIMIT = 60000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit fin [3];

  task automatic chk(input int g, input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL c%0d %s: got %0d expected %0d at t=%0t", g, name, act, exp, $time);
    end
  endtask

  for (genvar G = 0; G < 3; G++) begin : g_cfg
    localparam int NN   = (G == 0) ? 9 : (G == 1) ? 3 : 25;
    localparam int RS   = (G == 0) ? 3 : (G == 1) ? 1 : 5;
    localparam int LATX = (G == 2) ? 5 : 3;
    localparam int RW   = $clog2(NN);

    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [RW-1:0]  rank_sel = '0;
    logic           in_valid = 1'b0;
    logic [NN-1:0]  window = '0;
    logic           in_ready, bit_valid, bit_out, busy, done;
    logic [CWT-1:0] count;
    bit             exp_q [$];
    int             cyc_q [$];
    int             cyc = 0;

    sc_rank_filter_acc #(
      .N          (NN),
      .REG_STAGES (RS),
      .STREAM_LEN (LEN)
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_rank_sel  (rank_sel),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_window    (window),
      .o_bit_valid (bit_valid),
      .o_bit_out   (bit_out),
      .o_busy      (busy),
      .o_done      (done),
      .o_count     (count)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
      if (!rst) begin
        if (bit_valid) begin
          if (exp_q.size() == 0) begin
            chk(G, "spurious_bit_valid", 1, 0);
          end else begin
            chk(G, "bit_out", bit_out, exp_q.pop_front());
            chk(G, "latency", cyc - cyc_q.pop_front(), LATX);
          end
        end else begin
          chk(G, "bit_out_when_invalid", bit_out, 0);
        end
      end
    end

    initial begin : drv
      int rk, reff, mode, gap, rst_at, lit, acc, sum, k, nfr;
      bit mid_start, aborted, got, e;
      logic [NN-1:0] w, pat;

      repeat (3) @(posedge clk);
      #1;
      chk(G, "reset_done", done, 0);
      chk(G, "reset_busy", busy, 0);
      chk(G, "reset_in_ready", in_ready, 0);
      chk(G, "reset_bit_valid", bit_valid, 0);
      chk(G, "reset_bit_out", bit_out, 0);
      chk(G, "reset_count", count, 0);
      rst = 1'b0;

      nfr = (G == 0) ? 8 : 4;
      for (int f = 0; f < nfr; f++) begin
        mode = 2; gap = 2; rst_at = -1; lit = -1; mid_start = 0; pat = '0;
        rk = $urandom_range(0, (1 << RW) - 1);
        if (G == 0) begin
          case (f)
            0: begin rk = 4;  mode = 0; gap = 0; pat = NN'(9'h01F); lit = 256; end
            1: begin rk = 4;  mode = 0; gap = 0; pat = NN'(9'h00F); lit = 0;   end
            2: begin rk = 0;  mode = 0; gap = 0; pat = NN'(9'h1FE); lit = 0;   end
            3: begin rk = 8;  mode = 0; gap = 0; pat = NN'(9'h001); lit = 256; end
            4: begin rk = 15; mode = 0; gap = 0; pat = NN'(9'h001); lit = 256; end
            5: begin rk = 4;  mode = 1; gap = 1; lit = 128; end
            6: begin rk = 4;  rst_at = 100; end
            default: mid_start = 1;
          endcase
        end else if (f == 2) begin
          mid_start = 1;
        end

        @(posedge clk); #1;
        rank_sel = RW'(rk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reff = (rk >= NN) ? NN - 1 : rk;
        acc = 0; sum = 0; k = 0; aborted = 0;

        while (acc < LEN && k < 4000) begin
          in_valid = (gap == 0) ? 1'b1 : (gap == 1) ? ((k % 2) == 0) : ($urandom_range(0, 3) != 0);
          if (mode == 0)      w = pat;
          else if (mode == 1) w = ((acc % 2) == 0) ? NN'(9'h01F) : NN'(9'h00F);
          else                w = NN'($urandom);
          window = w;
          if (mid_start && acc == 50) begin
            start = 1'b1;
            rank_sel = RW'($urandom);
          end
          @(negedge clk);
          chk(G, "in_ready_run", in_ready, 1);
          chk(G, "busy_run", busy, 1);
          chk(G, "done_run", done, 0);
          if (in_valid) begin
            e = ($countones(w) >= NN - reff);
            exp_q.push_back(e);
            cyc_q.push_back(cyc);
            sum += int'(e);
            acc++;
          end
          @(posedge clk); #1;
          start = 1'b0;
          k++;
          if (acc == rst_at) begin
            rst = 1'b1;
            in_valid = 1'b0;
            exp_q.delete();
            cyc_q.delete();
            #1;
            chk(G, "midrst_done", done, 0);
            chk(G, "midrst_busy", busy, 0);
            chk(G, "midrst_in_ready", in_ready, 0);
            chk(G, "midrst_bit_valid", bit_valid, 0);
            chk(G, "midrst_count", count, 0);
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (20) begin
              @(negedge clk);
              chk(G, "no_done_after_reset", done, 0);
              chk(G, "idle_after_reset", busy, 0);
            end
            aborted = 1;
            break;
          end
        end

        if (!aborted) begin
          if (k >= 4000) chk(G, "accept_timeout", acc, LEN);
          got = 0;
          for (int t = 0; t < 40 && !got; t++) begin
            in_valid = $urandom_range(0, 1);
            window = NN'($urandom);
            @(negedge clk);
            chk(G, "in_ready_after_len", in_ready, 0);
            if (done) begin
              got = 1;
              chk(G, "count_model", count, sum);
              if (lit >= 0) chk(G, "count_literal", count, lit);
              chk(G, "busy_at_done", busy, 0);
              chk(G, "queue_drained", exp_q.size(), 0);
            end else begin
              @(posedge clk); #1;
            end
          end
          chk(G, "done_seen", got, 1);
          in_valid = 1'b0;
          @(negedge clk);
          chk(G, "done_single_pulse", done, 0);
          chk(G, "count_hold", count, sum);
        end
      end
      in_valid = 1'b0;
      fin[G] = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(fin[0] && fin[1] && fin[2]) && t < LIMIT) begin
      @(posedge clk);
      t++;
    end
    if (t >= LIMIT) begin
      n_cmp++;
      n_err++;
      $display("FAIL completion_timeout: got %0d cycles required under %0d", t, LIMIT);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sc_rank_filter_acc.md
Name: sc_rank_filter_acc

Overview:
- Parametrised stochastic-computing rank-order filter for N-element windows of unipolar bitstreams.
- Runtime-selectable order statistic: min, median, max or any rank.
- Pipelined AND/OR compare-and-swap sorting network.
- Integrated stochastic-to-binary accumulator with start/done framing.
- Sits between the SNG window assembler and the binary pixel writeback in image-filter apps.

Parameters:
- N, 9, window size in elements; odd, 3..25.
- REG_STAGES, 3, CAS network stages between pipeline registers; 1..N.
- STREAM_LEN, 256, bitstream length per frame; power of 2, 16..4096.
- RW, $clog2(N), width of rank_sel (derived localparam).
- CW, $clog2(STREAM_LEN+1), width of count (derived localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- rank_sel  in  RW  ascending rank to select (0 = min, N-1 = max); sampled on accepted start.
- in_valid  in  1  window bits valid this cycle.
- in_ready  out  1  block accepts a window this cycle.
- window  in  N  one stochastic bit per window element.
- bit_valid  out  1  bit_out is valid.
- bit_out  out  1  selected-rank stochastic bit.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse; count is valid.
- count  out  CW  number of 1s in the output stream for the finished frame; held until next start.

Behaviour:
- Reset is asynchronous and active-high on rst; all state is clocked on clk rising edge.
- Reset values: all outputs 0, state IDLE, pipeline valid bits cleared, latched rank = (N-1)/2.
- Bit function: for the latched rank r, the selected bit equals 1 iff popcount(window) >= N - r.
- Out-of-range rank: rank_sel >= N is clamped to N-1 when latched.
- Network structure: odd-even transposition network of N stages. Each CAS produces lo = a AND b, hi = a OR b. The rank tap is a mux over the N final lanes.
- Pipelining: a register follows every REG_STAGES stages, and the last stage plus the mux is always registered.
  - LAT = ceil(N/REG_STAGES) cycles from accepted window to bit_valid (defaults: 3).
  - The valid bit travels alongside the data.
- Handshake: a window is accepted when in_valid && in_ready. in_ready = (state==RUN) && (acc_cnt < STREAM_LEN). Gaps on in_valid are allowed at any time.
- FSM IDLE:
  - start clears acc_cnt and ones_cnt, latches rank, then goes to RUN.
  - done and count hold their previous values except that done is 0.
- FSM RUN:
  - Each accepted window increments acc_cnt.
  - When acc_cnt reaches STREAM_LEN, go to FLUSH (in_ready drops the same cycle the count reaches STREAM_LEN).
- FSM FLUSH: wait until the pipeline is empty (no valid bits in flight), then go to DONE.
- FSM DONE: count <= ones_cnt, done = 1 for exactly one cycle, return to IDLE.
- Accumulation: ones_cnt increments when bit_valid && bit_out, and is never wrapped. Maximum value STREAM_LEN fits in CW bits, so an all-ones stream reports STREAM_LEN exactly.
- start outside IDLE is ignored, with no effect on the rank or the counters.
- rank_sel changes mid-frame have no effect.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded and no done is produced.
- Simultaneous done and start: not possible, because start is only honoured in IDLE, which follows DONE by one cycle.
- bit_out is 0 whenever bit_valid is 0.

Decomposition:
- Package sc_pkg:
  - sc_state_e enum (IDLE, RUN, FLUSH, DONE).
  - Function clog2-based width helpers.
  - Function ceil_div used for LAT.
- Sub-module sc_cas_net: parametrised N-stage odd-even transposition AND/OR network with REG_STAGES pipelining.
  - Ports: clk, rst, in_valid, lanes in, lanes out, out_valid.
  - The top instantiates one sc_cas_net and contains the rank mux, FSM and counters.

Test Plan:
- Median, 5 ones: N=9, rank_sel=4, window=9'b000011111 every cycle, in_valid=1.
  -> bit_out=1 from cycle LAT=3 after the first accept; done after 256 accepts plus drain; count=256.
- Median, 4 ones: same setup with window=9'b000001111 -> bit_out=0 throughout; count=0.
- Min: rank_sel=0, window=9'b111111110 -> count=0.
- Max: rank_sel=8, window=9'b000000001 -> count=256.
- Clamp: rank_sel=15 behaves as rank 8.
- Mixed stream: rank_sel=4, windows alternating 9'b000011111 and 9'b000001111, in_valid high every other cycle.
  -> count=128; in_ready low after the 256th accept; done is exactly one pulse.
- Mid-frame reset: rst at accept 100 -> outputs zero, no done. A new start, run to completion -> correct count. start pulses issued during RUN are ignored (acc_cnt not cleared).
- Parameter sweep: N=3/REG_STAGES=1 (LAT=3) and N=25/REG_STAGES=5 (LAT=5), random windows.
  -> bit_out matches the popcount >= N-r model every cycle; count matches the model's sum.
